// File: rtl/xif_dummy_copro.sv
// Integer coprocessor on the core's eXtension interface. It decodes custom-0 instructions,
// runs them through a fixed-latency pipeline and returns the results in order from a small FIFO.
module xif_dummy_copro #(
   parameter int          LATENCY = 2,
   parameter int          DEPTH   = 4,
   parameter logic [6:0]  OPCODE  = 7'h0B
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             x_valid_i,
   output logic             x_ready_o,
   input  logic [31:0]      x_instr_i,
   input  logic [2:0][31:0] x_rs_i,
   input  logic [2:0]       x_rs_valid_i,
   output logic             x_accept_o,
   output logic             x_is_mem_op_o,
   output logic             x_writeback_o,
   output logic             x_rvalid_o,
   input  logic             x_rready_i,
   output logic [4:0]       x_rd_o,
   output logic [31:0]      x_data_o,
   output logic             x_dualwb_o,
   output logic             x_type_o,
   output logic             x_error_o
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [6:0]    opc_s;
   logic [2:0]    f3_s;
   logic [4:0]    rd_s;
   logic          claim_s;
   logic [31:0]   res_s;
   logic          err_s;
   logic          ready_s;
   logic          fire_s;
   logic          acc_s;
   logic          pop_s;
   logic          wr_s;

   logic [LATENCY-1:0] pv_q;
   logic [4:0]         prd_q  [LATENCY];
   logic [31:0]        pdat_q [LATENCY];
   logic               perr_q [LATENCY];

   logic [4:0]    mrd_q  [DEPTH];
   logic [31:0]   mdat_q [DEPTH];
   logic          merr_q [DEPTH];
   logic [PW-1:0] wp_q, wp_d;
   logic [PW-1:0] rp_q, rp_d;
   logic [CW-1:0] fcnt_q, fcnt_d;
   logic [CW-1:0] out_q, out_d;

   logic unused_s;
   assign unused_s = ^{x_instr_i[31:15], x_rs_i[2], x_rs_valid_i[2]};

   // Decode and compute the result for the instruction currently offered
   always_comb begin
      opc_s   = x_instr_i[6:0];
      f3_s    = x_instr_i[14:12];
      rd_s    = x_instr_i[11:7];
      res_s   = 32'h0000_0000;
      err_s   = 1'b0;
      claim_s = 1'b0;
      case (f3_s)
         3'b000: begin res_s = x_rs_i[0] + x_rs_i[1]; claim_s = (opc_s == OPCODE); end
         3'b001: begin res_s = x_rs_i[0] - x_rs_i[1]; claim_s = (opc_s == OPCODE); end
         3'b010: begin res_s = x_rs_i[0] ^ x_rs_i[1]; claim_s = (opc_s == OPCODE); end
         3'b011: begin res_s = x_rs_i[0] * x_rs_i[1]; claim_s = (opc_s == OPCODE); end
         3'b100: begin
            if ($signed(x_rs_i[0]) > $signed(x_rs_i[1])) begin
               res_s = x_rs_i[0];
            end else begin
               res_s = x_rs_i[1];
            end
            claim_s = (opc_s == OPCODE);
         end
         3'b111: begin res_s = 32'h0000_0000; err_s = 1'b1; claim_s = (opc_s == OPCODE); end
         default: begin res_s = 32'h0000_0000; err_s = 1'b0; claim_s = 1'b0; end
      endcase
   end

   // Credits cover pipeline plus FIFO entries, so the FIFO can never overflow
   assign ready_s = (out_q < CW'(DEPTH)) && x_rs_valid_i[0] && x_rs_valid_i[1];
   assign fire_s  = x_valid_i && ready_s;
   assign acc_s   = fire_s && claim_s;
   assign pop_s   = (fcnt_q != {CW{1'b0}}) && x_rready_i;
   assign wr_s    = pv_q[LATENCY-1];

   assign x_ready_o     = ready_s;
   assign x_accept_o    = claim_s;
   assign x_writeback_o = claim_s;
   assign x_is_mem_op_o = 1'b0;
   assign x_dualwb_o    = 1'b0;
   assign x_type_o      = 1'b0;

   // Compute pipeline: valid bits reset, payload just shifts
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pv_q <= '0;
      end else begin
         pv_q[0] <= acc_s;
         for (int i = 1; i < LATENCY; i++) begin
            pv_q[i] <= pv_q[i-1];
         end
      end
      prd_q[0]  <= rd_s;
      pdat_q[0] <= res_s;
      perr_q[0] <= err_s;
      for (int i = 1; i < LATENCY; i++) begin
         prd_q[i]  <= prd_q[i-1];
         pdat_q[i] <= pdat_q[i-1];
         perr_q[i] <= perr_q[i-1];
      end
   end

   // Next-state for FIFO pointers, FIFO fill level and outstanding credits
   always_comb begin
      wp_d   = wp_q;
      rp_d   = rp_q;
      fcnt_d = fcnt_q;
      out_d  = out_q;
      if (wr_s) begin
         wp_d = (wp_q == PW'(DEPTH - 1)) ? {PW{1'b0}} : wp_q + PW'(1);
      end else begin
         wp_d = wp_q;
      end
      if (pop_s) begin
         rp_d = (rp_q == PW'(DEPTH - 1)) ? {PW{1'b0}} : rp_q + PW'(1);
      end else begin
         rp_d = rp_q;
      end
      case ({wr_s, pop_s})
         2'b10:   fcnt_d = fcnt_q + CW'(1);
         2'b01:   fcnt_d = fcnt_q - CW'(1);
         default: fcnt_d = fcnt_q;
      endcase
      case ({acc_s, pop_s})
         2'b10:   out_d = out_q + CW'(1);
         2'b01:   out_d = out_q - CW'(1);
         default: out_d = out_q;
      endcase
   end

   // FIFO control state
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wp_q   <= '0;
         rp_q   <= '0;
         fcnt_q <= '0;
         out_q  <= '0;
      end else begin
         wp_q   <= wp_d;
         rp_q   <= rp_d;
         fcnt_q <= fcnt_d;
         out_q  <= out_d;
      end
   end

   // FIFO storage, written as results leave the last pipeline stage
   always_ff @(posedge clk_i) begin
      if (wr_s) begin
         mrd_q[wp_q]  <= prd_q[LATENCY-1];
         mdat_q[wp_q] <= pdat_q[LATENCY-1];
         merr_q[wp_q] <= perr_q[LATENCY-1];
      end
   end

   // Head is forced to zero while the FIFO is empty
   always_comb begin
      x_rvalid_o = (fcnt_q != {CW{1'b0}});
      if (x_rvalid_o) begin
         x_rd_o    = mrd_q[rp_q];
         x_data_o  = mdat_q[rp_q];
         x_error_o = merr_q[rp_q];
      end else begin
         x_rd_o    = 5'd0;
         x_data_o  = 32'h0000_0000;
         x_error_o = 1'b0;
      end
   end

endmodule

// File: tb/tb_xif_dummy_copro.sv
// Directed, table-driven bench for xif_dummy_copro with hand-written sequences for
// latency, backpressure, simultaneous accept/pop and reset corner cases.
module tb_xif_dummy_copro;

   logic             clk_i = 1'b0;
   logic             rst_i = 1'b1;
   logic             x_valid_i = 1'b0;
   logic             x_ready_o;
   logic [31:0]      x_instr_i = 32'h0;
   logic [2:0][31:0] x_rs_i = '0;
   logic [2:0]       x_rs_valid_i = 3'b011;
   logic             x_accept_o, x_is_mem_op_o, x_writeback_o, x_rvalid_o;
   logic             x_rready_i = 1'b0;
   logic [4:0]       x_rd_o;
   logic [31:0]      x_data_o;
   logic             x_dualwb_o, x_type_o, x_error_o;

   int n_vec = 0;
   int n_bad = 0;

   xif_dummy_copro dut (
      .clk_i(clk_i), .rst_i(rst_i), .x_valid_i(x_valid_i), .x_ready_o(x_ready_o),
      .x_instr_i(x_instr_i), .x_rs_i(x_rs_i), .x_rs_valid_i(x_rs_valid_i),
      .x_accept_o(x_accept_o), .x_is_mem_op_o(x_is_mem_op_o), .x_writeback_o(x_writeback_o),
      .x_rvalid_o(x_rvalid_o), .x_rready_i(x_rready_i), .x_rd_o(x_rd_o), .x_data_o(x_data_o),
      .x_dualwb_o(x_dualwb_o), .x_type_o(x_type_o), .x_error_o(x_error_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic        acc;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        err;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2);
      x_instr_i = instr;
      x_rs_i[0] = rs1;
      x_rs_i[1] = rs2;
      x_rs_i[2] = 32'h0;
   endtask

   // Wait (bounded) for a result and pop it
   task automatic get_result(output logic [4:0] rd, output logic [31:0] d, output logic e, output bit ok);
      ok = 1'b0;
      rd = 5'd0; d = 32'h0; e = 1'b0;
      x_rready_i = 1'b1;
      for (int k = 0; k < 20 && !ok; k++) begin
         @(negedge clk_i);
         if (x_rvalid_o) begin
            rd = x_rd_o; d = x_data_o; e = x_error_o; ok = 1'b1;
         end
         @(posedge clk_i); #1;
      end
      x_rready_i = 1'b0;
      if (!ok) chk("result_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      logic [4:0]  g_rd;
      logic [31:0] g_d;
      logic        g_e;
      bit          ok;
      bit          stray;
      int          acc_cyc, pop_cyc;
      logic [31:0] got [$];
      logic [31:0] exp_d [4];

      vecs[0] = '{32'h0000_058B, 32'd5,          32'd7,          1'b1, 5'd11, 32'd12,         1'b0};
      vecs[1] = '{32'h0000_118B, 32'd3,          32'd5,          1'b1, 5'd3,  32'hFFFF_FFFE,  1'b0};
      vecs[2] = '{32'h0000_220B, 32'hF0F0_1234,  32'h0FF0_0034,  1'b1, 5'd4,  32'hFF00_1200,  1'b0};
      vecs[3] = '{32'h0000_328B, 32'hFFFF_FFFF,  32'd2,          1'b1, 5'd5,  32'hFFFF_FFFE,  1'b0};
      vecs[4] = '{32'h0000_430B, 32'hFFFF_FFFF,  32'd1,          1'b1, 5'd6,  32'd1,          1'b0};
      vecs[5] = '{32'h0000_430B, 32'd7,          32'hFFFF_FFFB,  1'b1, 5'd6,  32'd7,          1'b0};
      vecs[6] = '{32'h0000_738B, 32'd9,          32'd9,          1'b1, 5'd7,  32'd0,          1'b1};
      vecs[7] = '{32'h0000_0133, 32'd1,          32'd2,          1'b0, 5'd0,  32'd0,          1'b0};
      vecs[8] = '{32'h0000_508B, 32'd1,          32'd2,          1'b0, 5'd0,  32'd0,          1'b0};
      vecs[9] = '{32'h0000_058B, 32'hFFFF_FFFF,  32'd1,          1'b1, 5'd11, 32'd0,          1'b0};

      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      chk("rst_rvalid", {31'd0, x_rvalid_o}, 32'd0);
      chk("rst_rd",     {27'd0, x_rd_o}, 32'd0);
      chk("rst_data",   x_data_o, 32'd0);
      chk("rst_error",  {31'd0, x_error_o}, 32'd0);
      chk("rst_ready",  {31'd0, x_ready_o}, 32'd1);
      chk("const_outs", {29'd0, x_is_mem_op_o, x_dualwb_o, x_type_o}, 32'd0);

      // Latency: handshake in cycle t, result visible in t+3
      @(posedge clk_i); #1;
      drive(32'h0000_058B, 32'd5, 32'd7);
      x_valid_i = 1'b1;
      x_rready_i = 1'b1;
      @(negedge clk_i);
      chk("lat_accept", {31'd0, x_accept_o}, 32'd1);
      @(posedge clk_i); #1;
      x_valid_i = 1'b0;
      @(negedge clk_i);
      chk("lat_t1_rvalid", {31'd0, x_rvalid_o}, 32'd0);
      @(negedge clk_i);
      chk("lat_t2_rvalid", {31'd0, x_rvalid_o}, 32'd0);
      @(negedge clk_i);
      chk("lat_t3_rvalid", {31'd0, x_rvalid_o}, 32'd1);
      chk("lat_rd",   {27'd0, x_rd_o}, 32'd11);
      chk("lat_data", x_data_o, 32'd12);
      @(posedge clk_i); #1;
      x_rready_i = 1'b0;

      // Table-driven single-instruction vectors
      for (int v = 0; v < 10; v++) begin
         drive(vecs[v].instr, vecs[v].rs1, vecs[v].rs2);
         x_valid_i = 1'b1;
         @(negedge clk_i);
         chk($sformatf("v%0d_accept", v), {31'd0, x_accept_o}, {31'd0, vecs[v].acc});
         chk($sformatf("v%0d_wb", v), {31'd0, x_writeback_o}, {31'd0, vecs[v].acc});
         chk($sformatf("v%0d_ready", v), {31'd0, x_ready_o}, 32'd1);
         @(posedge clk_i); #1;
         x_valid_i = 1'b0;
         if (vecs[v].acc) begin
            get_result(g_rd, g_d, g_e, ok);
            if (ok) begin
               chk($sformatf("v%0d_rd", v), {27'd0, g_rd}, {27'd0, vecs[v].rd});
               chk($sformatf("v%0d_data", v), g_d, vecs[v].data);
               chk($sformatf("v%0d_err", v), {31'd0, g_e}, {31'd0, vecs[v].err});
            end
            @(negedge clk_i);
            chk($sformatf("v%0d_empty", v), {31'd0, x_rvalid_o}, 32'd0);
         end else begin
            stray = 1'b0;
            x_rready_i = 1'b1;
            repeat (6) begin
               @(negedge clk_i);
               if (x_rvalid_o) stray = 1'b1;
            end
            x_rready_i = 1'b0;
            chk($sformatf("v%0d_no_result", v), {31'd0, stray}, 32'd0);
            chk($sformatf("v%0d_credit", v), {31'd0, x_ready_o}, 32'd1);
         end
         @(posedge clk_i); #1;
      end

      // Backpressure: four subs fill the credits, the fifth waits for a pop
      x_rready_i = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         drive(32'h0000_118B, i, 32'd1);
         x_valid_i = 1'b1;
         @(negedge clk_i);
         chk($sformatf("bp_ready%0d", i), {31'd0, x_ready_o}, 32'd1);
         @(posedge clk_i); #1;
      end
      drive(32'h0000_118B, 32'd5, 32'd1);
      x_rready_i = 1'b1;
      acc_cyc = -1;
      pop_cyc = -1;
      got.delete();
      for (int c = 0; c < 30 && got.size() < 5; c++) begin
         @(negedge clk_i);
         if (c == 0) chk("bp_full_ready", {31'd0, x_ready_o}, 32'd0);
         if (x_rvalid_o) begin
            got.push_back(x_data_o);
            if (pop_cyc < 0) pop_cyc = c;
         end
         if (x_valid_i && x_ready_o && acc_cyc < 0) acc_cyc = c;
         @(posedge clk_i); #1;
         if (acc_cyc >= 0) x_valid_i = 1'b0;
      end
      x_valid_i = 1'b0;
      x_rready_i = 1'b0;
      chk("bp_count", got.size(), 32'd5);
      for (int i = 0; i < got.size(); i++) chk($sformatf("bp_data%0d", i), got[i], i);
      chk("bp_accept_after_pop", acc_cyc, pop_cyc + 1);

      // Simultaneous pop and new request while full
      for (int i = 0; i < 4; i++) begin
         drive(32'h0000_058B, 32'd10 + i, 32'd0);
         x_valid_i = 1'b1;
         @(posedge clk_i); #1;
      end
      x_valid_i = 1'b0;
      repeat (4) @(posedge clk_i);
      #1;
      drive(32'h0000_058B, 32'd20, 32'd0);
      x_valid_i = 1'b1;
      x_rready_i = 1'b1;
      @(negedge clk_i);
      chk("sim_ready_full", {31'd0, x_ready_o}, 32'd0);
      chk("sim_head", x_data_o, 32'd10);
      @(posedge clk_i); #1;
      x_rready_i = 1'b0;
      @(negedge clk_i);
      chk("sim_ready_next", {31'd0, x_ready_o}, 32'd1);
      @(posedge clk_i); #1;
      x_valid_i = 1'b0;
      @(negedge clk_i);
      chk("sim_count_depth", {31'd0, x_ready_o}, 32'd0);
      @(posedge clk_i); #1;
      exp_d = '{32'd11, 32'd12, 32'd13, 32'd20};
      for (int i = 0; i < 4; i++) begin
         get_result(g_rd, g_d, g_e, ok);
         if (ok) chk($sformatf("sim_drain%0d", i), g_d, exp_d[i]);
      end

      // Operand-valid gating
      drive(32'h0000_058B, 32'd1, 32'd1);
      x_rs_valid_i = 3'b001;
      x_valid_i = 1'b1;
      @(negedge clk_i);
      chk("rsv001_ready", {31'd0, x_ready_o}, 32'd0);
      x_rs_valid_i = 3'b110;
      #1;
      chk("rsv110_ready", {31'd0, x_ready_o}, 32'd0);
      @(posedge clk_i); #1;
      x_valid_i = 1'b0;
      x_rs_valid_i = 3'b011;

      // Reset with three results in flight
      for (int i = 0; i < 3; i++) begin
         drive(32'h0000_058B, 32'd100 + i, 32'd0);
         x_valid_i = 1'b1;
         @(posedge clk_i); #1;
      end
      x_valid_i = 1'b0;
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("rst_mid_rvalid", {31'd0, x_rvalid_o}, 32'd0);
      chk("rst_mid_ready",  {31'd0, x_ready_o}, 32'd1);
      stray = 1'b0;
      x_rready_i = 1'b1;
      repeat (8) begin
         @(negedge clk_i);
         if (x_rvalid_o) stray = 1'b1;
      end
      x_rready_i = 1'b0;
      chk("rst_mid_stale", {31'd0, stray}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
